// File: rtl/dmem_pkg.sv
// Shared constants, request record and address-split helpers for the banked data memory.
package dmem_pkg;

   localparam int DMEM_DATA_WIDTH = 128;
   localparam int DMEM_DEPTH      = 512;
   localparam int DMEM_NUM_BANKS  = 4;
   localparam int DMEM_NUM_PORTS  = 2;
   localparam int DMEM_AW         = $clog2(DMEM_DEPTH);
   localparam int DMEM_BE         = DMEM_DATA_WIDTH / 8;

   typedef struct packed {
      logic [DMEM_AW-1:0]         addr;
      logic                       wen;
      logic [DMEM_BE-1:0]         be;
      logic [DMEM_DATA_WIDTH-1:0] wdata;
   } dmem_req_t;

   // Low address bits select the bank; bw = 0 maps everything to bank 0.
   function automatic int unsigned bank_of(input int unsigned addr, input int unsigned bw);
      return addr & ((32'd1 << bw) - 32'd1);
   endfunction

   function automatic int unsigned row_of(input int unsigned addr, input int unsigned bw);
      return addr >> bw;
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port RAM bank: synchronous read, byte-lane write strobes, contents not reset.
module dmem_bank
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int ROWS       = DMEM_DEPTH / DMEM_NUM_BANKS,
   parameter int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
)(
   input  logic                    clk,
   input  logic                    en,
   input  logic                    we,
   input  logic [RW-1:0]           row,
   input  logic [DATA_WIDTH/8-1:0] be,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);

   localparam int BE = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [ROWS];
   logic [DATA_WIDTH-1:0] rdata_reg;

   // Read register only moves on a read so the last word stays visible.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < BE; i++) begin
               if (be[i]) begin
                  mem[row][8*i +: 8] <= wdata[8*i +: 8];
               end
            end
         end else begin
            rdata_reg <= mem[row];
         end
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/dmem_banked.sv
// Multi-port, word-interleaved banked data memory with per-bank round-robin arbitration.
module dmem_banked
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = DMEM_DATA_WIDTH,
   parameter int DEPTH      = DMEM_DEPTH,
   parameter int NUM_BANKS  = DMEM_NUM_BANKS,
   parameter int NUM_PORTS  = DMEM_NUM_PORTS
)(
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic [NUM_PORTS-1:0]                  req_valid,
   output logic [NUM_PORTS-1:0]                  req_ready,
   input  logic [NUM_PORTS*$clog2(DEPTH)-1:0]    req_addr,
   input  logic [NUM_PORTS-1:0]                  req_wen,
   input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   req_be,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]       req_wdata,
   output logic [NUM_PORTS-1:0]                  rsp_valid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]       rsp_rdata,
   output logic [31:0]                           conflict_cnt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int BW   = $clog2(NUM_BANKS);
   localparam int BE   = DATA_WIDTH / 8;
   localparam int ROWS = DEPTH / NUM_BANKS;
   localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int BIW  = (BW > 0) ? BW : 1;
   localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef struct packed {
      logic [AW-1:0]         addr;
      logic                  wen;
      logic [BE-1:0]         be;
      logic [DATA_WIDTH-1:0] wdata;
   } port_req_t;

   port_req_t             req        [NUM_PORTS];
   logic [BIW-1:0]        port_bank  [NUM_PORTS];
   logic [RW-1:0]         port_row   [NUM_PORTS];

   logic [NUM_PORTS-1:0]  grant      [NUM_BANKS];
   logic [PW-1:0]         rr_ptr_reg [NUM_BANKS];
   logic [PW-1:0]         rr_ptr_next[NUM_BANKS];
   logic                  found;
   int                    idx;

   logic [NUM_BANKS-1:0]  bank_en;
   logic [NUM_BANKS-1:0]  bank_we;
   logic [RW-1:0]         bank_row   [NUM_BANKS];
   logic [BE-1:0]         bank_be    [NUM_BANKS];
   logic [DATA_WIDTH-1:0] bank_wdata [NUM_BANKS];
   logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];

   logic [31:0]           lost;
   logic [32:0]           conflict_sum;
   logic [31:0]           conflict_cnt_reg;
   logic [31:0]           conflict_cnt_next;

   logic [NUM_PORTS-1:0]  rsp_valid_reg;
   logic [BIW-1:0]        rsp_bank_reg [NUM_PORTS];
   logic [DATA_WIDTH-1:0] rsp_hold_reg [NUM_PORTS];
   logic [DATA_WIDTH-1:0] rsp_word     [NUM_PORTS];

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : gen_port
      assign req[gi]       = {req_addr[gi*AW +: AW], req_wen[gi],
                              req_be[gi*BE +: BE], req_wdata[gi*DATA_WIDTH +: DATA_WIDTH]};
      assign port_bank[gi] = BIW'(bank_of(32'(req[gi].addr), 32'(BW)));
      assign port_row[gi]  = RW'(row_of(32'(req[gi].addr), 32'(BW)));
      // Outside a response cycle the port shows the last word it was given.
      assign rsp_word[gi]  = rsp_valid_reg[gi] ? bank_rdata[rsp_bank_reg[gi]] : rsp_hold_reg[gi];
      assign rsp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rsp_word[gi];
   end

   always_comb begin
      found = 1'b0;
      idx   = 0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         grant[b]       = '0;
         rr_ptr_next[b] = rr_ptr_reg[b];
         found          = 1'b0;
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_ptr_reg[b]) + k) % NUM_PORTS;
            if (!found && req_valid[idx] && (int'(port_bank[idx]) == b)) begin
               grant[b][idx]  = 1'b1;
               rr_ptr_next[b] = PW'((idx + 1) % NUM_PORTS);
               found          = 1'b1;
            end
         end
      end
   end

   // Grants made under reset still show as ready but never reach a bank.
   always_comb begin
      req_ready = '0;
      bank_en   = '0;
      bank_we   = '0;
      lost      = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_row[b]   = '0;
         bank_be[b]    = '0;
         bank_wdata[b] = '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (grant[b][p]) begin
               req_ready[p]  = 1'b1;
               bank_en[b]    = rst_n;
               bank_we[b]    = req[p].wen;
               bank_row[b]   = port_row[p];
               bank_be[b]    = req[p].be;
               bank_wdata[b] = req[p].wdata;
            end
         end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
         lost = lost + 32'(req_valid[p] & ~req_ready[p]);
      end
   end

   assign conflict_sum      = {1'b0, conflict_cnt_reg} + {1'b0, lost};
   assign conflict_cnt_next = conflict_sum[32] ? '1 : conflict_sum[31:0];

   for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : gen_bank
      dmem_bank #(
         .DATA_WIDTH (DATA_WIDTH),
         .ROWS       (ROWS),
         .RW         (RW)
      ) u_bank (
         .clk   (clk),
         .en    (bank_en[gi]),
         .we    (bank_we[gi]),
         .row   (bank_row[gi]),
         .be    (bank_be[gi]),
         .wdata (bank_wdata[gi]),
         .rdata (bank_rdata[gi])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            rr_ptr_reg[b] <= '0;
         end
         conflict_cnt_reg <= '0;
         rsp_valid_reg    <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_bank_reg[p] <= '0;
            rsp_hold_reg[p] <= '0;
         end
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            rr_ptr_reg[b] <= rr_ptr_next[b];
         end
         conflict_cnt_reg <= conflict_cnt_next;
         for (int p = 0; p < NUM_PORTS; p++) begin
            rsp_valid_reg[p] <= req_ready[p] & ~req_wen[p];
            if (req_ready[p]) begin
               rsp_bank_reg[p] <= port_bank[p];
            end
            rsp_hold_reg[p] <= rsp_word[p];
         end
      end
   end

   assign rsp_valid    = rsp_valid_reg;
   assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked at default parameters: sweep, vector tables, reset and saturation sequences.
module tb_dmem_banked;
   import dmem_pkg::*;

   localparam int P  = 2;
   localparam int DW = 128;
   localparam int AW = 9;
   localparam int BE = 16;

   logic              clk;
   logic              rst_n;
   logic [P-1:0]      req_valid;
   logic [P-1:0]      req_ready;
   logic [P*AW-1:0]   req_addr;
   logic [P-1:0]      req_wen;
   logic [P*BE-1:0]   req_be;
   logic [P*DW-1:0]   req_wdata;
   logic [P-1:0]      rsp_valid;
   logic [P*DW-1:0]   rsp_rdata;
   logic [31:0]       conflict_cnt;

   int checks = 0;
   int errors = 0;

   dmem_banked dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_wen      (req_wen),
      .req_be       (req_be),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .conflict_cnt (conflict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   valid;
      dmem_req_t    r0;
      dmem_req_t    r1;
      logic [1:0]   exp_ready;
      logic [1:0]   exp_rspv;
      logic [127:0] exp_rd0;
      logic [127:0] exp_rd1;
      logic [31:0]  exp_cnt;
   } vec_t;

   localparam logic [127:0] D    = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
   localparam logic [127:0] X120 = 128'h0000_0000_0000_0000_5555_6666_7777_8888;
   localparam logic [127:0] E    = 128'hCAFE_F00D_0123_4567_89AB_CDEF_0F0F_F0F0;
   localparam logic [127:0] F    = 128'hDEAD_BEEF_1234_5678_9ABC_DEF0_A5A5_5A5A;
   localparam logic [127:0] ONES = '1;

   vec_t vecs [19];

   function automatic dmem_req_t rq(input logic [8:0] a, input logic w,
                                    input logic [15:0] be, input logic [127:0] d);
      dmem_req_t r;
      r.addr  = a;
      r.wen   = w;
      r.be    = be;
      r.wdata = d;
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, input dmem_req_t r0, input dmem_req_t r1);
      req_valid = v;
      req_addr  = {r1.addr, r0.addr};
      req_wen   = {r1.wen, r0.wen};
      req_be    = {r1.be, r0.be};
      req_wdata = {r1.wdata, r0.wdata};
   endtask

   task automatic run_vectors(input int first, input int last);
      for (int i = first; i <= last; i++) begin
         drive(vecs[i].valid, vecs[i].r0, vecs[i].r1);
         #1;
         $display("vec %0d: valid=%b ready=%b rsp_valid=%b cnt=%0d",
                  i, req_valid, req_ready, rsp_valid, conflict_cnt);
         chk($sformatf("vec%0d.ready", i), 128'(req_ready), 128'(vecs[i].exp_ready));
         chk($sformatf("vec%0d.rsp_valid", i), 128'(rsp_valid), 128'(vecs[i].exp_rspv));
         chk($sformatf("vec%0d.rdata0", i), rsp_rdata[127:0], vecs[i].exp_rd0);
         chk($sformatf("vec%0d.rdata1", i), rsp_rdata[255:128], vecs[i].exp_rd1);
         chk($sformatf("vec%0d.cnt", i), 128'(conflict_cnt), 128'(vecs[i].exp_cnt));
         @(negedge clk);
      end
   endtask

   initial begin
      dmem_req_t idle;
      idle = rq(9'd0, 1'b0, 16'h0, 128'h0);

      // Segment A: runs after the sweep (bank 0 pointer sits at port 1)
      vecs[0]  = '{2'b01, rq(9'd120, 1'b1, 16'h00FF, D), idle, 2'b01, 2'b00, 128'd511, 128'd0, 32'd0};
      vecs[1]  = '{2'b01, rq(9'd120, 1'b0, 16'h0, 128'h0), idle, 2'b01, 2'b00, 128'd511, 128'd0, 32'd0};
      vecs[2]  = '{2'b11, rq(9'd121, 1'b0, 16'h0, 128'h0), rq(9'd122, 1'b1, 16'hFFFF, E),
                   2'b11, 2'b01, X120, 128'd0, 32'd0};
      vecs[3]  = '{2'b10, idle, rq(9'd122, 1'b0, 16'h0, 128'h0), 2'b10, 2'b01, 128'd121, 128'd0, 32'd0};
      vecs[4]  = '{2'b00, idle, idle, 2'b00, 2'b10, 128'd121, E, 32'd0};
      vecs[5]  = '{2'b01, rq(9'd123, 1'b1, 16'h0000, ONES), idle, 2'b01, 2'b00, 128'd121, E, 32'd0};
      vecs[6]  = '{2'b01, rq(9'd123, 1'b0, 16'h0, 128'h0), idle, 2'b01, 2'b00, 128'd121, E, 32'd0};
      vecs[7]  = '{2'b00, idle, idle, 2'b00, 2'b01, 128'd123, E, 32'd0};
      vecs[8]  = '{2'b11, rq(9'd124, 1'b0, 16'h0, 128'h0), rq(9'd128, 1'b1, 16'hFFFF, F),
                   2'b10, 2'b00, 128'd123, E, 32'd0};
      vecs[9]  = '{2'b01, rq(9'd124, 1'b0, 16'h0, 128'h0), idle, 2'b01, 2'b00, 128'd123, E, 32'd1};
      vecs[10] = '{2'b01, rq(9'd128, 1'b0, 16'h0, 128'h0), idle, 2'b01, 2'b01, 128'd124, E, 32'd1};
      vecs[11] = '{2'b00, idle, idle, 2'b00, 2'b01, F, E, 32'd1};
      // Segment B: runs after the mid-test reset (pointers back at 0)
      vecs[12] = '{2'b11, rq(9'd120, 1'b0, 16'h0, 128'h0), rq(9'd124, 1'b0, 16'h0, 128'h0),
                   2'b01, 2'b00, 128'd0, 128'd0, 32'd0};
      vecs[13] = '{2'b11, rq(9'd120, 1'b0, 16'h0, 128'h0), rq(9'd124, 1'b0, 16'h0, 128'h0),
                   2'b10, 2'b01, X120, 128'd0, 32'd1};
      vecs[14] = '{2'b11, rq(9'd120, 1'b0, 16'h0, 128'h0), rq(9'd124, 1'b0, 16'h0, 128'h0),
                   2'b01, 2'b10, X120, 128'd124, 32'd2};
      vecs[15] = '{2'b11, rq(9'd120, 1'b0, 16'h0, 128'h0), rq(9'd124, 1'b0, 16'h0, 128'h0),
                   2'b10, 2'b01, X120, 128'd124, 32'd3};
      vecs[16] = '{2'b00, idle, idle, 2'b00, 2'b10, X120, 128'd124, 32'd4};
      vecs[17] = '{2'b10, idle, rq(9'd125, 1'b0, 16'h0, 128'h0), 2'b10, 2'b00, X120, 128'd124, 32'd4};
      vecs[18] = '{2'b00, idle, idle, 2'b00, 2'b10, X120, 128'd125, 32'd4};

      rst_n = 1'b0;
      drive(2'b00, idle, idle);
      for (int r = 0; r < 128; r++) begin
         dut.gen_bank[0].u_bank.mem[r] = 128'(4*r + 0);
         dut.gen_bank[1].u_bank.mem[r] = 128'(4*r + 1);
         dut.gen_bank[2].u_bank.mem[r] = 128'(4*r + 2);
         dut.gen_bank[3].u_bank.mem[r] = 128'(4*r + 3);
      end
      repeat (2) @(negedge clk);
      $display("reset: rsp_valid=%b cnt=%0d", rsp_valid, conflict_cnt);
      chk("reset.rsp_valid", 128'(rsp_valid), 128'd0);
      chk("reset.rsp_rdata", rsp_rdata[127:0] | rsp_rdata[255:128], 128'd0);
      chk("reset.cnt", 128'(conflict_cnt), 128'd0);
      rst_n = 1'b1;

      // Back-to-back read sweep on port 0
      for (int n = 0; n <= 512; n++) begin
         if (n < 512) drive(2'b01, rq(9'(n), 1'b0, 16'h0, 128'h0), idle);
         else         drive(2'b00, idle, idle);
         #1;
         $display("sweep %0d: ready=%b rsp_valid=%b rdata0=%0d", n, req_ready, rsp_valid, rsp_rdata[127:0]);
         if (n < 512) chk($sformatf("sweep%0d.ready", n), 128'(req_ready), 128'd1);
         if (n > 0) begin
            chk($sformatf("sweep%0d.rsp_valid", n), 128'(rsp_valid), 128'd1);
            chk($sformatf("sweep%0d.rdata0", n), rsp_rdata[127:0], 128'(n - 1));
         end else begin
            chk("sweep0.rsp_valid", 128'(rsp_valid), 128'd0);
         end
         if (n == 512) chk("sweep.cnt", 128'(conflict_cnt), 128'd0);
         @(negedge clk);
      end

      run_vectors(0, 11);

      // Read grant, then reset for two cycles while a write to the same word is attempted
      drive(2'b01, rq(9'd125, 1'b0, 16'h0, 128'h0), idle);
      #1;
      $display("rst seq 0: ready=%b", req_ready);
      chk("rstseq.grant", 128'(req_ready), 128'd1);
      @(negedge clk);
      rst_n = 1'b0;
      drive(2'b10, idle, rq(9'd125, 1'b1, 16'hFFFF, ONES));
      #1;
      $display("rst seq 1: rsp_valid=%b rdata0=%0d", rsp_valid, rsp_rdata[127:0]);
      chk("rstseq.rsp_valid", 128'(rsp_valid), 128'd1);
      chk("rstseq.rdata0", rsp_rdata[127:0], 128'd125);
      @(negedge clk);
      #1;
      $display("rst seq 2: rsp_valid=%b cnt=%0d", rsp_valid, conflict_cnt);
      chk("rstseq.rsp_valid_cleared", 128'(rsp_valid), 128'd0);
      chk("rstseq.rdata_cleared", rsp_rdata[127:0] | rsp_rdata[255:128], 128'd0);
      chk("rstseq.cnt_cleared", 128'(conflict_cnt), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      drive(2'b00, idle, idle);
      #1;
      $display("rst seq 3: rsp_valid=%b cnt=%0d", rsp_valid, conflict_cnt);
      chk("rstseq.rsp_valid_after", 128'(rsp_valid), 128'd0);
      @(negedge clk);

      run_vectors(12, 18);

      // Counter saturation
      dut.conflict_cnt_reg = 32'hFFFF_FFFE;
      drive(2'b11, rq(9'd120, 1'b0, 16'h0, 128'h0), rq(9'd124, 1'b0, 16'h0, 128'h0));
      #1;
      $display("sat 0: cnt=0x%0h", conflict_cnt);
      chk("sat.preset", 128'(conflict_cnt), 128'hFFFF_FFFE);
      for (int s = 1; s <= 2; s++) begin
         @(negedge clk);
         #1;
         $display("sat %0d: ready=%b cnt=0x%0h", s, req_ready, conflict_cnt);
         chk($sformatf("sat%0d.cnt", s), 128'(conflict_cnt), 128'hFFFF_FFFF);
      end
      drive(2'b00, idle, idle);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
